// File: rtl/npc_redirect.sv
// npc_redirect: fetch PC register and next-PC selection.
// Computes branch, J and JR targets from the ID-stage instruction.
// A redirect that arrives while fetch is stalled is latched until the stall drops.
// Exception entry and ERET override everything except reset.
module npc_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] id_pc,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        j_valid,
  input  logic [25:0] j_index,
  input  logic        jr_valid,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  output logic        redir_pend,
  output logic        pc_misalign
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] pend_target;
  logic [31:0] pend_next;

  logic [31:0] id_pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] redir_tgt;
  logic        redir;

  // Candidate targets. All adds wrap modulo 2^32.
  // The J target takes its top nibble from the delay-slot address.
  assign id_pc_plus4 = id_pc + 32'd4;
  assign br_tgt      = id_pc_plus4 + {{14{br_imm[15]}}, br_imm, 2'b00};
  assign j_tgt       = {id_pc_plus4[31:28], j_index, 2'b00};
  assign redir       = (br_valid & br_taken) | j_valid | jr_valid;

  // Choose the redirect target. If the decoder ever asserts more than one
  // valid, J wins over JR, and JR wins over a taken branch.
  always_comb begin
    redir_tgt = br_tgt;
    if (j_valid)
      redir_tgt = j_tgt;
    else if (jr_valid)
      redir_tgt = jr_target;
  end

  // Next-PC, pending-target and state selection, in priority order.
  // Exception entry and ERET bypass the stall and drop any latched redirect.
  // While in HOLD and still stalled, new redirect inputs are ignored, so the
  // same branch being re-presented in ID does no harm.
  always_comb begin
    pc_next    = pc;
    state_next = state;
    pend_next  = pend_target;
    if (exc_req) begin
      pc_next    = EXC_VEC;
      state_next = RUN;
    end else if (eret_req) begin
      pc_next    = epc;
      state_next = RUN;
    end else if (state == RUN) begin
      if (redir && !stall) begin
        pc_next = redir_tgt;
      end else if (redir && stall) begin
        pend_next  = redir_tgt;
        state_next = HOLD;
      end else if (!stall) begin
        pc_next = pc + 32'd4;
      end
    end else begin
      if (!stall) begin
        pc_next    = pend_target;
        state_next = RUN;
      end
    end
  end

  // State register. Reset takes priority over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      state       <= RUN;
      pend_target <= '0;
    end else begin
      pc          <= pc_next;
      state       <= state_next;
      pend_target <= pend_next;
    end
  end

  // Link value for JAL/JALR/BxxAL, pending flag, and fetch alignment fault.
  assign pc_plus8    = id_pc + 32'd8;
  assign redir_pend  = (state == HOLD);
  assign pc_misalign = |pc[1:0];

endmodule
